// File: rtl/channel_shift_reg_pkg.sv
// Shared constants and helpers for the channel PRN code generator.
// Holds the LFSR width, the BOC sub-counter width and the masked XOR reduction
// that forms both the LFSR feedback bit and the LFSR output bit.
package channel_shift_reg_pkg;

  localparam int LFSR_W    = 32;
  localparam int BOC_CNT_W = 8;

  // Parity of the bits selected by mask: feedback taps or output taps.
  function automatic logic xor_mask(input logic [LFSR_W-1:0] vec,
                                    input logic [LFSR_W-1:0] mask);
    return ^(vec & mask);
  endfunction

endpackage

// File: rtl/channel_lfsr.sv
// One 32-bit Fibonacci LFSR with a programmable feedback mask, an output tap
// mask and a chip-period counter. When the counter reaches its terminal value,
// the LFSR reloads its reset state instead of shifting, and wrap_o flags that
// chip. A load has priority over a coincident shift.
module channel_lfsr
  import channel_shift_reg_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LFSR_W-1:0] state_i,
  input  logic [LFSR_W-1:0] reset_state_i,
  input  logic [LFSR_W-1:0] bitmask_i,
  input  logic [LFSR_W-1:0] out_bitmask_i,
  input  logic [LFSR_W-1:0] length_i,
  input  logic [LFSR_W-1:0] init_i,
  input  logic              load_i,
  input  logic              shift_i,
  output logic [LFSR_W-1:0] sr_o,
  output logic              out_o,
  output logic              wrap_o
);

  logic [LFSR_W-1:0] sr_q, sr_d;
  logic [LFSR_W-1:0] cnt_q, cnt_d;
  logic              fb;

  // Next state: load, wrap to the reset state at the period end, or shift in feedback.
  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    fb     = xor_mask(sr_q, bitmask_i);
    wrap_o = shift_i & ~load_i & (cnt_q == length_i);
    if (load_i) begin
      sr_d  = state_i;
      cnt_d = init_i;
    end else if (shift_i) begin
      if (cnt_q == length_i) begin
        sr_d  = reset_state_i;
        cnt_d = '0;
      end else begin
        sr_d  = {sr_q[LFSR_W-2:0], fb};
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State and counter registers, cleared by the synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign sr_o  = sr_q;
  assign out_o = xor_mask(sr_q, out_bitmask_i);

endmodule

// File: rtl/channel_shift_reg.sv
// Per-channel PRN code generator: two independent LFSRs whose outputs are XORed
// into the code chip. An init request is held pending until an epoch strobe,
// and LFSR1 period wraps are reported as a one-cycle prn_reset pulse.
// Optional BOC subcarrier (macro BOC_MOD_EN): a sub-chip counter gates LFSR
// advances and a square-wave subcarrier term is XORed into code_out.
// reset_n is an active-high synchronous reset despite its name.
module channel_shift_reg
  import channel_shift_reg_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [LFSR_W-1:0]    code_state1,
  input  logic [LFSR_W-1:0]    code_reset_state1,
  input  logic [LFSR_W-1:0]    code_bitmask1,
  input  logic [LFSR_W-1:0]    code_out_bitmask1,
  input  logic [LFSR_W-1:0]    code_state2,
  input  logic [LFSR_W-1:0]    code_reset_state2,
  input  logic [LFSR_W-1:0]    code_bitmask2,
  input  logic [LFSR_W-1:0]    code_out_bitmask2,
  input  logic [LFSR_W-1:0]    prn_length,
  input  logic [LFSR_W-1:0]    prn_init,
  input  logic [LFSR_W-1:0]    prn_length1,
  input  logic [LFSR_W-1:0]    prn_init1,
  input  logic                 doinit,
  input  logic                 intr_pulse,
  input  logic                 shift,
`ifdef BOC_MOD_EN
  input  logic [BOC_CNT_W-1:0] sub_cnt_init,
  input  logic [0:0]           sub_code_init,
  input  logic [BOC_CNT_W-1:0] sub_ratio,
  input  logic [BOC_CNT_W-1:0] shift_ratio,
`endif
  output logic [LFSR_W-1:0]    sr1,
  output logic [LFSR_W-1:0]    sr2,
  output logic                 code_out,
  output logic                 prn_reset
);

  logic init_pending_q, init_pending_d;
  logic prn_reset_q, prn_reset_d;
  logic init_apply;
  logic advance;
  logic sub_term;
  logic out1, out2;
  logic wrap1;
  logic unused_wrap2;

  assign init_apply = (doinit | init_pending_q) & intr_pulse;

`ifdef BOC_MOD_EN
  logic [BOC_CNT_W-1:0] sub_cnt_q, sub_cnt_d;
  logic                 sub_code_q, sub_code_d;
  logic                 sub_last;
  logic [BOC_CNT_W:0]   sub_cnt_inc;

  // Sub-chip counter and subcarrier phase; only the last sub-chip advances the code.
  always_comb begin
    sub_cnt_d   = sub_cnt_q;
    sub_code_d  = sub_code_q;
    sub_last    = (sub_cnt_q == (sub_ratio - 8'd1));
    sub_cnt_inc = {1'b0, sub_cnt_q} + 9'd1;
    if (init_apply) begin
      sub_cnt_d  = sub_cnt_init;
      sub_code_d = sub_code_init[0];
    end else if (shift) begin
      sub_cnt_d = sub_last ? '0 : sub_cnt_inc[BOC_CNT_W-1:0];
      // A zero half-period ratio is treated as "subcarrier off" rather than dividing by zero.
      if ((shift_ratio != '0) && ((sub_cnt_inc % {1'b0, shift_ratio}) == '0)) begin
        sub_code_d = ~sub_code_q;
      end
    end
  end

  // Subcarrier registers.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      sub_cnt_q  <= '0;
      sub_code_q <= 1'b0;
    end else begin
      sub_cnt_q  <= sub_cnt_d;
      sub_code_q <= sub_code_d;
    end
  end

  assign advance  = shift & ~init_apply & sub_last;
  assign sub_term = sub_code_q;
`else
  assign advance  = shift & ~init_apply;
  assign sub_term = 1'b0;
`endif

  channel_lfsr u_lfsr1 (
    .clk_i         (clk),
    .rst_i         (reset_n),
    .state_i       (code_state1),
    .reset_state_i (code_reset_state1),
    .bitmask_i     (code_bitmask1),
    .out_bitmask_i (code_out_bitmask1),
    .length_i      (prn_length),
    .init_i        (prn_init),
    .load_i        (init_apply),
    .shift_i       (advance),
    .sr_o          (sr1),
    .out_o         (out1),
    .wrap_o        (wrap1)
  );

  channel_lfsr u_lfsr2 (
    .clk_i         (clk),
    .rst_i         (reset_n),
    .state_i       (code_state2),
    .reset_state_i (code_reset_state2),
    .bitmask_i     (code_bitmask2),
    .out_bitmask_i (code_out_bitmask2),
    .length_i      (prn_length1),
    .init_i        (prn_init1),
    .load_i        (init_apply),
    .shift_i       (advance),
    .sr_o          (sr2),
    .out_o         (out2),
    .wrap_o        (unused_wrap2)
  );

  // Pending-init tracking and the LFSR1 wrap pulse for the next cycle.
  always_comb begin
    init_pending_d = init_pending_q;
    if (init_apply) begin
      init_pending_d = 1'b0;
    end else if (doinit) begin
      init_pending_d = 1'b1;
    end
    prn_reset_d = wrap1;
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      init_pending_q <= 1'b0;
      prn_reset_q    <= 1'b0;
    end else begin
      init_pending_q <= init_pending_d;
      prn_reset_q    <= prn_reset_d;
    end
  end

  assign prn_reset = prn_reset_q;
  assign code_out  = out1 ^ out2 ^ sub_term;

endmodule

// File: tb/tb_channel_shift_reg.sv
// Scoreboard bench for channel_shift_reg: a behavioural model is stepped with
// each cycle's stimulus, the expected post-edge state is queued, and it is
// popped and compared one time unit after the clock edge.
module tb_channel_shift_reg;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] code_state1, code_reset_state1, code_bitmask1, code_out_bitmask1;
  logic [31:0] code_state2, code_reset_state2, code_bitmask2, code_out_bitmask2;
  logic [31:0] prn_length, prn_init, prn_length1, prn_init1;
  logic        doinit, intr_pulse, shift;
  logic [31:0] sr1, sr2;
  logic        code_out, prn_reset;
`ifdef BOC_MOD_EN
  logic [7:0]  sub_cnt_init;
  logic [0:0]  sub_code_init;
  logic [7:0]  sub_ratio, shift_ratio;
`endif

  always #5 clk = ~clk;

  channel_shift_reg dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .code_state1       (code_state1),
    .code_reset_state1 (code_reset_state1),
    .code_bitmask1     (code_bitmask1),
    .code_out_bitmask1 (code_out_bitmask1),
    .code_state2       (code_state2),
    .code_reset_state2 (code_reset_state2),
    .code_bitmask2     (code_bitmask2),
    .code_out_bitmask2 (code_out_bitmask2),
    .prn_length        (prn_length),
    .prn_init          (prn_init),
    .prn_length1       (prn_length1),
    .prn_init1         (prn_init1),
    .doinit            (doinit),
    .intr_pulse        (intr_pulse),
    .shift             (shift),
`ifdef BOC_MOD_EN
    .sub_cnt_init      (sub_cnt_init),
    .sub_code_init     (sub_code_init),
    .sub_ratio         (sub_ratio),
    .shift_ratio       (shift_ratio),
`endif
    .sr1               (sr1),
    .sr2               (sr2),
    .code_out          (code_out),
    .prn_reset         (prn_reset)
  );

  typedef struct {
    logic [31:0] sr1;
    logic [31:0] sr2;
    logic        code_out;
    logic        prn_reset;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state
  logic [31:0] m_sr1, m_sr2, m_cnt1, m_cnt2;
  logic        m_pend, m_prn;
  logic [7:0]  m_sub_cnt;
  logic        m_sub_code;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic red(input logic [31:0] v, input logic [31:0] m);
    return ^(v & m);
  endfunction

  task automatic model_step();
    logic apply;
    logic adv;
    if (reset_n) begin
      m_sr1 = '0; m_sr2 = '0; m_cnt1 = '0; m_cnt2 = '0;
      m_pend = 1'b0; m_prn = 1'b0; m_sub_cnt = '0; m_sub_code = 1'b0;
    end else begin
      apply = (doinit | m_pend) & intr_pulse;
      m_prn = 1'b0;
      if (apply) begin
        m_sr1 = code_state1; m_sr2 = code_state2;
        m_cnt1 = prn_init;   m_cnt2 = prn_init1;
        m_pend = 1'b0;
`ifdef BOC_MOD_EN
        m_sub_cnt = sub_cnt_init; m_sub_code = sub_code_init[0];
`endif
      end else begin
        if (doinit) m_pend = 1'b1;
        if (shift) begin
          adv = 1'b1;
`ifdef BOC_MOD_EN
          begin
            logic [7:0] lim;
            int nxt;
            lim = sub_ratio - 8'd1;
            nxt = int'(m_sub_cnt) + 1;
            adv = (m_sub_cnt == lim);
            if (shift_ratio != 0 && (nxt % int'(shift_ratio)) == 0) m_sub_code = ~m_sub_code;
            m_sub_cnt = adv ? 8'd0 : 8'(nxt);
          end
`endif
          if (adv) begin
            if (m_cnt1 == prn_length) begin
              m_cnt1 = '0; m_sr1 = code_reset_state1; m_prn = 1'b1;
            end else begin
              m_cnt1 = m_cnt1 + 1;
              m_sr1  = {m_sr1[30:0], red(m_sr1, code_bitmask1)};
            end
            if (m_cnt2 == prn_length1) begin
              m_cnt2 = '0; m_sr2 = code_reset_state2;
            end else begin
              m_cnt2 = m_cnt2 + 1;
              m_sr2  = {m_sr2[30:0], red(m_sr2, code_bitmask2)};
            end
          end
        end
      end
    end
  endtask

  // One clock: model the edge, queue expectation, let the DUT clock, then score.
  task automatic tick();
    exp_t e;
    model_step();
    e.sr1       = m_sr1;
    e.sr2       = m_sr2;
    e.prn_reset = m_prn;
    e.code_out  = red(m_sr1, code_out_bitmask1) ^ red(m_sr2, code_out_bitmask2);
`ifdef BOC_MOD_EN
    e.code_out  = e.code_out ^ m_sub_code;
`endif
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sr1", sr1, e.sr1);
      check("sr2", sr2, e.sr2);
      check("code_out", 32'(code_out), 32'(e.code_out));
      check("prn_reset", 32'(prn_reset), 32'(e.prn_reset));
    end
  endtask

  // Shift n times with gap idle cycles between, checking wrap spacing and code repetition.
  task automatic run_period(input int n, input int gap, input int period, input bit chk_first);
    logic seq[$];
    int   since = 0;
    int   wraps = 0;
    for (int s = 0; s < n; s++) begin
      shift = 1'b1;
      tick();
      shift = 1'b0;
      since++;
      seq.push_back(code_out);
      if (chk_first && s == 0) check("first_shift_sr1", sr1, 32'hFFFF_FFFE);
      if (prn_reset) begin
        wraps++;
        check("wrap_period", since, period);
        check("wrap_sr1", sr1, 32'hFFFF_FFFF);
        since = 0;
      end
      if (s >= period) check("code_repeat", 32'(seq[s]), 32'(seq[s-period]));
      repeat (gap) tick();
    end
    check("wrap_count", wraps, n / period);
  endtask

  initial begin
    reset_n = 1'b1;
    code_state1 = '0; code_reset_state1 = '0; code_bitmask1 = '0; code_out_bitmask1 = '0;
    code_state2 = '0; code_reset_state2 = '0; code_bitmask2 = '0; code_out_bitmask2 = '0;
    prn_length = '0; prn_init = '0; prn_length1 = '0; prn_init1 = '0;
    doinit = 1'b0; intr_pulse = 1'b0; shift = 1'b0;
`ifdef BOC_MOD_EN
    sub_cnt_init = '0; sub_code_init = '0; sub_ratio = 8'd1; shift_ratio = 8'd0;
`endif

    // Reset held for 20 cycles
    repeat (20) tick();
    check("rst_sr1", sr1, 32'h0);
    check("rst_code_out", 32'(code_out), 32'h0);
    reset_n = 1'b0;

    // Test-plan configuration
    code_state1 = 32'hFFFF_FFFF; code_reset_state1 = 32'hFFFF_FFFF;
    code_bitmask1 = 32'h0880_0000; code_out_bitmask1 = 32'h0200_0000;
    prn_length = 32'd510; prn_init = 32'd0;
    prn_length1 = 32'd510; prn_init1 = 32'd0;

    // Init without epoch: nothing loads
    doinit = 1'b1;
    tick();
    doinit = 1'b0;
    check("no_epoch_sr1", sr1, 32'h0);
    repeat (9) tick();

    // Deferred init applies on the epoch
    intr_pulse = 1'b1;
    tick();
    check("deferred_sr1", sr1, 32'hFFFF_FFFF);
    intr_pulse = 1'b0;
    tick();

    // Perturb, then immediate init with the epoch high
    repeat (3) begin
      shift = 1'b1; tick(); shift = 1'b0; tick();
    end
    intr_pulse = 1'b1;
    doinit = 1'b1;
    tick();
    doinit = 1'b0;
    check("imm_sr1", sr1, 32'hFFFF_FFFF);
    check("imm_code_out", 32'(code_out), 32'h1);

    // Period 511, shift every 4th cycle
    run_period(1100, 3, 511, 1'b1);

    // Random LFSR2, LFSR1 wrapping on every shift, random strobes
    prn_length = 32'd0;
    code_state2 = $urandom; code_reset_state2 = $urandom;
    code_bitmask2 = $urandom; code_out_bitmask2 = $urandom;
    prn_length1 = 32'd6; prn_init1 = 32'd2;
    doinit = 1'b1;
    tick();
    doinit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      shift      = 1'($urandom_range(0, 1));
      doinit     = ($urandom_range(0, 15) == 0);
      intr_pulse = ($urandom_range(0, 3) == 0);
      tick();
    end
    shift = 1'b0; doinit = 1'b0;

    // Init and shift collide: init wins, no advance
    code_state1 = 32'h1234_5678;
    intr_pulse = 1'b1; doinit = 1'b1; shift = 1'b1;
    tick();
    doinit = 1'b0; shift = 1'b0;
    check("collide_sr1", sr1, 32'h1234_5678);
    check("collide_prn", 32'(prn_reset), 32'h0);

    // Reset mid-operation clears a pending init
    intr_pulse = 1'b0; doinit = 1'b1;
    tick();
    doinit = 1'b0; reset_n = 1'b1;
    tick();
    reset_n = 1'b0; intr_pulse = 1'b1;
    tick();
    check("pend_cleared_sr1", sr1, 32'h0);

`ifdef BOC_MOD_EN
    // BOC: 4 shifts per chip, subcarrier half-period of 2 shifts
    code_state1 = 32'hFFFF_FFFF;
    code_state2 = '0; code_reset_state2 = '0; code_bitmask2 = '0; code_out_bitmask2 = '0;
    prn_length = 32'd510; prn_init = 32'd0;
    sub_ratio = 8'd4; shift_ratio = 8'd2; sub_cnt_init = '0; sub_code_init = '0;
    doinit = 1'b1;
    tick();
    doinit = 1'b0;
    run_period(2100, 1, 2044, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/channel_shift_reg.md
Name: channel_shift_reg

Overview:
- Per-channel PRN code generator for the correlator/imitator channel.
- Two independent 32-bit Fibonacci LFSRs, each with programmable taps, output-tap mask, reset state and chip-period counter.
- Code output is the XOR of the two LFSR outputs. It advances one chip per `shift` strobe and emits a period-wrap pulse (`prn_reset`).

Parameters:
- None. All state, mask and length fields are fixed at 32 bits.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, ACTIVE-HIGH: asserted when 1 (codebase port name retained)
- code_state1  in  32  LFSR1 state loaded on init
- code_reset_state1  in  32  LFSR1 state loaded at period wrap
- code_bitmask1  in  32  LFSR1 feedback tap mask
- code_out_bitmask1  in  32  LFSR1 output tap mask
- code_state2, code_reset_state2, code_bitmask2, code_out_bitmask2  in  32 each  same fields for LFSR2
- prn_length  in  32  LFSR1 terminal chip count (period = prn_length+1)
- prn_init  in  32  LFSR1 chip counter value loaded on init
- prn_length1  in  32  LFSR2 terminal chip count
- prn_init1  in  32  LFSR2 chip counter value loaded on init
- doinit  in  1  request reload of states/counters
- intr_pulse  in  1  epoch strobe; init is applied only on a cycle where this is 1
- shift  in  1  chip-advance strobe, 1-cycle pulse
- sr1, sr2  out  32  current LFSR registers
- code_out  out  1  code chip
- prn_reset  out  1  1-cycle pulse at LFSR1 period wrap

Behaviour:
- Reset (reset_n=1 at clk edge): sr1=sr2=0, cnt1=cnt2=0, init_pending=0, prn_reset=0. code_out is therefore 0.
- fbK = XOR-reduce(srK & code_bitmaskK).
- outK = XOR-reduce(srK & code_out_bitmaskK).
- code_out = out1 ^ out2. It is combinational from registers, so it reflects srK in the same cycle.
- Init request: doinit=1 sets init_pending.
- Init apply: when (doinit | init_pending) & intr_pulse, on that edge:
  - sr1<=code_state1, sr2<=code_state2
  - cnt1<=prn_init, cnt2<=prn_init1
  - init_pending<=0
- Init has priority over a coincident `shift`; that shift is discarded.
- Advance (shift=1, no init), LFSR1:
  - if cnt1==prn_length: cnt1<=0, sr1<=code_reset_state1, prn_reset<=1 (next cycle, width 1)
  - else: cnt1<=cnt1+1, sr1<={sr1[30:0], fb1}
- Advance, LFSR2: identical, using cnt2, prn_length1 and code_reset_state2. LFSR2 wrap does not drive prn_reset.
- No shift: all state holds; prn_reset<=0.
- prn_length=0: wrap on every shift.
- prn_init>prn_length: counter runs to 2^32-1, then wraps via overflow to 0 with no pulse. This is unsupported configuration; no error flag.
- All-zero masks: fb=0 and out=0, so that LFSR contributes 0 to code_out.
- reset_n mid-operation clears everything, including init_pending.

Optional Feature:
- Macro: BOC_MOD_EN.
- Adds inputs:
  - sub_cnt_init [7:0], sub_code_init [0:0]
  - sub_ratio [7:0]: shifts per chip
  - shift_ratio [7:0]: shifts per subcarrier half-period
- Adds state sub_cnt (8 bits) and sub_code (1 bit).
  - Init loads both from the *_init inputs.
  - Reset clears both.
- Each shift: sub_cnt <= (sub_cnt==sub_ratio-1) ? 0 : sub_cnt+1.
- sub_code toggles on a shift when (sub_cnt+1) mod shift_ratio == 0.
- LFSR/counter advance occurs only on shifts where sub_cnt==sub_ratio-1.
- code_out = out1 ^ out2 ^ sub_code.
- Without the macro: ports are absent; every shift advances the LFSRs; no subcarrier term.

Decomposition:
- Shared package: LFSR width constant (32), BOC counter width (8), and the XOR-reduce-of-masked-vector function.
- One natural sub-module, channel_lfsr: state, reset state, taps, out mask, length, init, shift, load → sr, out, wrap. Instantiated twice.

Test Plan:
- Reset: hold reset_n=1 for 20 cycles → sr1=sr2=0, code_out=0, prn_reset=0.
- Init without epoch: intr_pulse=0, doinit pulse → sr unchanged.
- Deferred init: raise intr_pulse 10 cycles after doinit → sr1 loads on that edge.
- Init immediate apply: intr_pulse=1; code_state1=FFFFFFFF, bitmask1=08800000, out_bitmask1=02000000, LFSR2 zeroed, prn_length=510; pulse doinit → next edge sr1=FFFFFFFF, code_out=1.
- First shift: with the above, shift every 4th cycle → after first shift sr1=FFFFFFFE (fb=0).
- Period: prn_reset pulses exactly every 511 shifts; sr1=FFFFFFFF after each wrap; code sequence repeats with period 511.
- Init/shift collision: doinit and shift in the same cycle → init values loaded, no advance.
- BOC_MOD_EN: sub_ratio=4, shift_ratio=2, init sub_code=0 → sub_code toggles every 2 shifts; LFSR advances every 4 shifts; prn_reset every 2044 shifts.
